pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer for the fetch stage: sequential fetch, branch/jump
// redirects with a fixed bubble window, and a saturating redirect counter.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  input  logic [1:0]  BS,
  input  logic        PS,
  input  logic        Z,
  input  logic [31:0] BrA,
  input  logic [31:0] RAA,
  input  logic        stall,
  input  logic        imem_ready,
  output logic [15:0] pc,
  output logic        imem_req,
  output logic        fetch_valid,
  output logic        flush,
  output logic [7:0]  redirect_cnt
);

  localparam int unsigned PC_W   = 16;
  localparam int unsigned BCNT_W = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [BCNT_W-1:0]   w_bcnt_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_redirect;
  logic [PC_W-1:0]     w_target;
  logic                w_unused_bits;

  assign w_unused_bits = ^{BrA[31:16], RAA[31:16]};

  // Taken-branch decode from the execute stage
  always_comb begin
    w_redirect = 1'b0;
    w_target   = BrA[PC_W-1:0];
    if (br_valid) begin
      unique case (BS)
        2'd1:    w_redirect = (Z != PS);
        2'd2:    begin w_redirect = 1'b1; w_target = RAA[PC_W-1:0]; end
        2'd3:    w_redirect = 1'b1;
        default: w_redirect = 1'b0;
      endcase
    end
  end

  // Next-state and output logic; redirect overrides stall and any state
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_bcnt_nxt  = r_bcnt;
    w_cnt_nxt   = r_cnt;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    flush       = 1'b0;

    unique case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && !stall) begin
          fetch_valid = 1'b1;
          w_pc_nxt    = r_pc + PC_W'(1);
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (r_bcnt == '0) w_state_nxt = S_FETCH;
        else              w_bcnt_nxt  = r_bcnt - BCNT_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_redirect) begin
      w_pc_nxt    = w_target;
      w_state_nxt = S_FLUSH;
      w_bcnt_nxt  = BCNT_W'(FLUSH_CYCLES - 1);
      flush       = 1'b1;
      fetch_valid = 1'b0;
      if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    // Outputs read as reset values for the whole time reset is held
    if (rst) begin
      imem_req    = 1'b0;
      fetch_valid = 1'b0;
      flush       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_bcnt  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign pc           = r_pc;
  assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checks of pc_sequencer against a bubble-count
// reference model.
module tb_pc_sequencer;

  localparam logic [15:0] RESET_PC     = 16'h0000;
  localparam int          FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [1:0]  BS;
  logic        PS;
  logic        Z;
  logic [31:0] BrA;
  logic [31:0] RAA;
  logic        stall;
  logic        imem_ready;
  logic [15:0] pc;
  logic        imem_req;
  logic        fetch_valid;
  logic        flush;
  logic [7:0]  redirect_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch has started?, bubbles still owed, pc, redirect count
  bit started;
  int bubbles;
  int m_pc;
  int m_cnt;

  pc_sequencer #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .BS(BS), .PS(PS), .Z(Z),
    .BrA(BrA), .RAA(RAA), .stall(stall), .imem_ready(imem_ready),
    .pc(pc), .imem_req(imem_req), .fetch_valid(fetch_valid), .flush(flush),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    started = 1'b0;
    bubbles = 0;
    m_pc    = int'(RESET_PC);
    m_cnt   = 0;
  endtask

  task automatic set_in(input bit bv, input int bs, input bit ps, input bit z,
                        input logic [31:0] bra, input logic [31:0] raa,
                        input bit st, input bit rdy);
    br_valid = bv; BS = 2'(bs); PS = ps; Z = z; BrA = bra; RAA = raa;
    stall = st; imem_ready = rdy;
  endtask

  // Called right after a falling edge with inputs applied; checks, then advances one cycle
  task automatic step(input string tag);
    bit redir, e_req, e_fv, e_flush;
    int target;
    #1;
    if (rst) model_reset();
    redir  = !rst && br_valid && (BS == 2'd3 || BS == 2'd2 || (BS == 2'd1 && Z != PS));
    target = (BS == 2'd2) ? int'(RAA[15:0]) : int'(BrA[15:0]);
    e_req   = !rst && started && bubbles == 0;
    e_fv    = e_req && imem_ready && !stall && !redir;
    e_flush = !rst && (redir || bubbles > 0);
    chk({tag, ".pc"},       32'(pc),           32'(m_pc));
    chk({tag, ".cnt"},      32'(redirect_cnt), 32'(m_cnt));
    chk({tag, ".imem_req"}, 32'(imem_req),     32'(e_req));
    chk({tag, ".fv"},       32'(fetch_valid),  32'(e_fv));
    chk({tag, ".flush"},    32'(flush),        32'(e_flush));
    @(posedge clk);
    if (!rst) begin
      if (redir) begin
        m_pc    = target;
        bubbles = FLUSH_CYCLES;
        started = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end else if (!started) begin
        started = 1'b1;
      end else if (bubbles > 0) begin
        bubbles--;
      end else if (e_fv) begin
        m_pc = (m_pc + 1) % 65536;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    step("reset");
    step("reset_hold");

    // Release, sequential fetch: pc 0,0,1,2,3
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("seq");

    // Taken conditional branch to 0x40
    set_in(1, 1, 0, 1, 32'h0000_0040, 0, 0, 1);
    step("br_taken");
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("br_after");
    chk("br_cnt", 32'(redirect_cnt), 32'd1);

    // Not-taken conditional
    set_in(1, 1, 1, 1, 32'h0000_0999, 0, 0, 1);
    step("br_nt");
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    step("br_nt_after");

    // Jump-register overrides stall
    set_in(1, 2, 0, 0, 32'h0000_5555, 32'h0000_1234, 1, 1);
    step("jr_stall");
    chk("jr_pc", 32'(pc), 32'h1234);
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step("stall_hold");

    // Wrap at 0xFFFF, then redirect in first bubble cycle restarts the bubble
    set_in(1, 3, 0, 0, 32'hABCD_FFFF, 0, 0, 1);
    step("to_ffff");
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("wrap");
    chk("wrap_pc", 32'(pc), 32'h0000);
    set_in(1, 3, 0, 0, 32'h0000_0100, 0, 0, 1);
    step("rd1");
    set_in(1, 3, 0, 0, 32'h0000_0200, 0, 0, 1);
    step("rd_in_flush");
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    step("bubble1");
    step("bubble2");
    step("resume");

    // Redirect taken straight out of IDLE
    rst = 1'b1; step("rst2");
    rst = 1'b0;
    set_in(1, 2, 0, 0, 0, 32'h0000_0777, 0, 1);
    step("idle_redir");
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("idle_after");

    // Asynchronous reset in the middle of a bubble
    set_in(1, 3, 0, 0, 32'h0000_0321, 0, 0, 1);
    step("pre_async");
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_pc",    32'(pc),           32'(RESET_PC));
    chk("async_flush", 32'(flush),        32'd0);
    chk("async_cnt",   32'(redirect_cnt), 32'd0);
    chk("async_req",   32'(imem_req),     32'd0);
    model_reset();
    @(negedge clk);
    step("async_hold");
    rst = 1'b0;

    // Saturation of redirect counter
    for (int i = 0; i < 260; i++) begin
      set_in(1, 3, 0, 0, $urandom, 0, 0, 1);
      step("sat");
    end
    chk("sat_cnt", 32'(redirect_cnt), 32'hFF);

    rst = 1'b1; step("rst3");
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      set_in(($urandom_range(0, 99) < 15), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom, $urandom,
             ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 75));
      rst = ($urandom_range(0, 199) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
